pulse_peak_detector: RTL

Sits directly downstream of the shaping filter and consumes its free-running output stream, one signed sample per `clk`. Detects each shaped pulse that crosses a programmable threshold and captures its peak amplitude, peak timestamp and width above threshold. Delivers one record per pulse over a valid/ready interface to the readout logic. Rejects narrow noise spikes and applies a post-pulse hold-off.

---
 rtl/package_settings.sv | 4 +
 rtl/peak_parameters.sv | 24 ++
 rtl/pulse_peak_detector_if.sv | 23 ++
 rtl/peak_output_slot.sv | 61 ++++++
 rtl/pulse_peak_detector.sv | 115 +++++++++++
 5 files changed

// File: rtl/package_settings.sv
// Shared system settings; filter samples are SIZE_FILTER_DATA+1 bits wide, signed.
package package_settings;
    localparam int SIZE_FILTER_DATA = 15;
endpackage

// File: rtl/peak_parameters.sv
// Types and defaults shared by the pulse peak detector, its interface and its output slot.
package peak_parameters;
    import package_settings::*;

    localparam int THRESHOLD_DEFAULT = 100;
    localparam int MIN_WIDTH_DEFAULT = 2;
    localparam int HOLDOFF_DEFAULT   = 4;
    localparam int TS_MAX_WIDTH      = 64;

    typedef logic signed [SIZE_FILTER_DATA:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HOLDOFF
    } peak_state_e;

    // Timestamp field is sized for the widest supported counter; narrower ones are zero-extended.
    typedef struct packed {
        sample_t                 amplitude;
        logic [TS_MAX_WIDTH-1:0] timestamp;
        logic [7:0]              width;
    } peak_record_t;
endpackage

// File: rtl/pulse_peak_detector_if.sv
// Peak record stream from the detector to the readout logic (valid/ready plus drop counter).
interface pulse_peak_detector_if #(
    parameter int TS_WIDTH = 32
);
    import package_settings::*;

    logic                             peak_valid;
    logic                             peak_ready;
    logic signed [SIZE_FILTER_DATA:0] peak_amplitude;
    logic [TS_WIDTH-1:0]              peak_time;
    logic [7:0]                       peak_width;
    logic [15:0]                      lost_count;

    modport master (
        output peak_valid, peak_amplitude, peak_time, peak_width, lost_count,
        input  peak_ready
    );

    modport slave (
        input  peak_valid, peak_amplitude, peak_time, peak_width, lost_count,
        output peak_ready
    );
endinterface

// File: rtl/peak_output_slot.sv
// One-deep valid/ready holding register for peak records; counts records dropped while full.
module peak_output_slot
    import peak_parameters::*;
#(
    parameter int TS_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          emit_i,
    input  peak_record_t                  record_i,
    pulse_peak_detector_if.master         peak_if
);
    logic         valid_q, valid_d;
    peak_record_t rec_q, rec_d;
    logic [15:0]  lost_q, lost_d;
    logic         accept;
    logic         load;

    // A record being drained on this edge frees the slot for a simultaneous load.
    always_comb begin
        accept  = valid_q && peak_if.peak_ready;
        load    = emit_i && (!valid_q || accept);
        valid_d = valid_q;
        rec_d   = rec_q;
        lost_d  = lost_q;
        if (load) begin
            valid_d = 1'b1;
            rec_d   = record_i;
        end else if (accept) begin
            valid_d = 1'b0;
        end
        if (emit_i && !load && (lost_q != 16'hFFFF)) begin
            lost_d = lost_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            rec_q   <= '0;
            lost_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rec_q   <= rec_d;
            lost_q  <= lost_d;
        end
    end

    assign peak_if.peak_valid     = valid_q;
    assign peak_if.peak_amplitude = rec_q.amplitude;
    assign peak_if.peak_time      = rec_q.timestamp[TS_WIDTH-1:0];
    assign peak_if.peak_width     = rec_q.width;
    assign peak_if.lost_count     = lost_q;

    generate
        if (TS_WIDTH < TS_MAX_WIDTH) begin : g_ts_hi
            logic unused_ts_hi;
            assign unused_ts_hi = ^rec_q.timestamp[TS_MAX_WIDTH-1:TS_WIDTH];
        end
    endgenerate
endmodule

// File: rtl/pulse_peak_detector.sv
// Threshold-triggered pulse detector: tracks peak amplitude, peak timestamp and width of each pulse.
module pulse_peak_detector
    import package_settings::*;
    import peak_parameters::*;
#(
    parameter int THRESHOLD = THRESHOLD_DEFAULT,
    parameter int MIN_WIDTH = MIN_WIDTH_DEFAULT,
    parameter int HOLDOFF   = HOLDOFF_DEFAULT,
    parameter int TS_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic signed [SIZE_FILTER_DATA:0] filter_data,
    pulse_peak_detector_if.master            peak_if
);
    localparam sample_t            THRESH_S = sample_t'(THRESHOLD);
    localparam logic [7:0]         MIN_W8   = 8'(MIN_WIDTH);
    localparam logic [7:0]         HOLD8    = 8'(HOLDOFF);
    localparam logic [TS_WIDTH-1:0] TS_ONE  = {{(TS_WIDTH-1){1'b0}}, 1'b1};

    peak_state_e         state_q, state_d;
    logic [TS_WIDTH-1:0] ts_q;
    sample_t             x_q;
    logic [TS_WIDTH-1:0] tag_q;
    sample_t             max_q, max_d;
    logic [TS_WIDTH-1:0] max_ts_q, max_ts_d;
    logic [7:0]          width_q, width_d;
    logic [7:0]          hold_q, hold_d;
    logic                above;
    logic                emit;
    peak_record_t        record;

    assign above = (x_q > THRESH_S);

    // Each registered sample carries the timestamp of the edge that captured it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ts_q     <= '0;
            x_q      <= '0;
            tag_q    <= '0;
            max_q    <= '0;
            max_ts_q <= '0;
            width_q  <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            ts_q     <= ts_q + TS_ONE;
            x_q      <= filter_data;
            tag_q    <= ts_q;
            max_q    <= max_d;
            max_ts_q <= max_ts_d;
            width_q  <= width_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (above) state_d = ST_ARMED;
            ST_ARMED:   if (!above) state_d = (width_q >= MIN_W8) ? ST_HOLDOFF : ST_IDLE;
            ST_HOLDOFF: if (hold_q == 8'd1) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        emit     = 1'b0;
        max_d    = max_q;
        max_ts_d = max_ts_q;
        width_d  = width_q;
        hold_d   = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (above) begin
                    max_d    = x_q;
                    max_ts_d = tag_q;
                    width_d  = 8'd1;
                end
            end
            ST_ARMED: begin
                if (above) begin
                    if (width_q != 8'hFF) width_d = width_q + 8'd1;
                    // Strictly greater keeps the earliest sample of a flat top.
                    if (x_q > max_q) begin
                        max_d    = x_q;
                        max_ts_d = tag_q;
                    end
                end else if (width_q >= MIN_W8) begin
                    emit   = 1'b1;
                    hold_d = HOLD8;
                end
            end
            ST_HOLDOFF: hold_d = hold_q - 8'd1;
            default: ;
        endcase
    end

    always_comb begin
        record.amplitude = max_q;
        record.timestamp = TS_MAX_WIDTH'(max_ts_q);
        record.width     = width_q;
    end

    peak_output_slot #(
        .TS_WIDTH (TS_WIDTH)
    ) u_slot (
        .clk      (clk),
        .reset    (reset),
        .emit_i   (emit),
        .record_i (record),
        .peak_if  (peak_if)
    );
endmodule
